// File: rtl/eth_pkg.sv
// Shared Ethernet constants: CRC-32 parameters and legal frame length bounds.
package eth_pkg;

   localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;

   localparam int ETH_MIN_LEN = 64;
   localparam int ETH_MAX_LEN = 1522;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } rx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32, one byte per call, LSB first. Purely combinational so the
// receive checker and the transmit FCS generator can share it.
module crc32_d8
   import eth_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  dat,
   output logic [31:0] crc_out
);

   logic [31:0] c;

   // Eight serial LFSR steps unrolled into one combinational cone
   always_comb begin
      c = crc_in;
      for (int i = 0; i < 8; i++) begin
         if (c[0] ^ dat[i])
            c = (c >> 1) ^ CRC32_POLY;
         else
            c = c >> 1;
      end
      crc_out = c;
   end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS checker: runs CRC-32 over every byte including the FCS, holds
// the last four bytes back so the FCS never reaches the output, and flags the
// last payload byte when the frame is bad (CRC, runt, oversize or aborted).
module eth_rx_fcs_check
   import eth_pkg::*;
#(
   parameter int MIN_LEN = ETH_MIN_LEN,
   parameter int MAX_LEN = ETH_MAX_LEN,
   parameter int CNT_W   = 16
)
(
   input  logic             clk_mac,
   input  logic             rst,
   input  logic             rx_vld,
   input  logic [7:0]       rx_dat,
   input  logic             rx_sof,
   input  logic             rx_eof,
   output logic             out_vld,
   output logic [7:0]       out_dat,
   output logic             out_sof,
   output logic             out_eof,
   output logic             out_err,
   output logic             stat_good,
   output logic             stat_bad,
   output logic [CNT_W-1:0] good_cnt,
   output logic [CNT_W-1:0] bad_cnt
);

   rx_state_t   state;
   logic [7:0]  sr [0:3];
   logic [15:0] count;
   logic [31:0] crc;

   logic [31:0] crc_seed;
   logic [31:0] crc_next;
   logic [16:0] len;
   logic        frame_err;

   // A new frame (sof) always restarts from the init value, even mid-frame
   assign crc_seed = (state == ST_FRAME && !rx_sof) ? crc : CRC32_INIT;

   crc32_d8 u_crc (
      .crc_in  (crc_seed),
      .dat     (rx_dat),
      .crc_out (crc_next)
   );

   // Length the frame would have if the current byte ends it
   assign len       = {1'b0, count} + 17'd1;
   assign frame_err = (crc_next != CRC32_RESIDUE) ||
                      (len < 17'(MIN_LEN)) || (len > 17'(MAX_LEN));

   // Frame FSM with delay line, registered output strobes and counters
   always_ff @(posedge clk_mac or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         count     <= '0;
         crc       <= CRC32_INIT;
         for (int i = 0; i < 4; i++) sr[i] <= '0;
         out_vld   <= 1'b0;
         out_dat   <= '0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         out_err   <= 1'b0;
         stat_good <= 1'b0;
         stat_bad  <= 1'b0;
         good_cnt  <= '0;
         bad_cnt   <= '0;
      end else begin
         out_vld   <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         out_err   <= 1'b0;
         stat_good <= 1'b0;
         stat_bad  <= 1'b0;

         if (rx_vld && (rx_sof || state == ST_FRAME)) begin
            // Every accepted byte enters the delay line and the CRC
            sr[0] <= rx_dat;
            for (int i = 1; i < 4; i++) sr[i] <= sr[i-1];
            crc <= crc_next;

            if (rx_sof) begin
               // Abort of an in-progress frame: close it out if it has
               // already put bytes on the output, otherwise drop it quietly
               if (state == ST_FRAME) begin
                  stat_bad <= 1'b1;
                  if (count >= 16'd5) begin
                     out_vld <= 1'b1;
                     out_dat <= sr[3];
                     out_eof <= 1'b1;
                     out_err <= 1'b1;
                  end
               end
               count <= 16'd1;
               if (rx_eof) begin
                  // Single-byte frame: bad, nothing emitted
                  stat_bad <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  state <= ST_FRAME;
               end
               // Abort and a one-byte frame on the same byte are two bad frames
               if (state == ST_FRAME && rx_eof)
                  bad_cnt <= bad_cnt + CNT_W'(2);
               else if (state == ST_FRAME || rx_eof)
                  bad_cnt <= bad_cnt + CNT_W'(1);
            end else begin
               count <= (count == 16'hFFFF) ? count : count + 16'd1;
               if (count >= 16'd4) begin
                  out_vld <= 1'b1;
                  out_dat <= sr[3];
                  out_sof <= (count == 16'd4);
               end
               if (rx_eof) begin
                  if (count >= 16'd4) begin
                     out_eof <= 1'b1;
                     out_err <= frame_err;
                  end
                  if (frame_err) begin
                     stat_bad <= 1'b1;
                     bad_cnt  <= bad_cnt + CNT_W'(1);
                  end else begin
                     stat_good <= 1'b1;
                     good_cnt  <= good_cnt + CNT_W'(1);
                  end
                  state <= ST_IDLE;
               end
            end
         end
      end
   end

endmodule

// File: doc/eth_rx_fcs_check.md
Name: eth_rx_fcs_check

Overview:
- Stage directly downstream of eth_rx, in the clk_mac (50 MHz RMII) domain.
- Consumes the eth_rx byte stream (rx_vld/rx_dat/rx_sof/rx_eof; no backpressure) and runs CRC-32 over every byte, including the FCS.
- Strips the 4 trailing FCS bytes through a 4-byte delay line.
- Re-emits the payload stream with a per-frame error flag on the last byte, plus good/bad frame counters for the status logic.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes, FCS included; shorter frames are flagged bad.
- MAX_LEN, 1522, maximum legal frame length in bytes, FCS included; longer frames are flagged bad.
- CNT_W, 16, width of the good/bad frame counters.

Ports:
- clk_mac  in  1  MAC clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- rx_vld  in  1  input byte valid; one-cycle strobe per byte.
- rx_dat  in  8  input byte.
- rx_sof  in  1  first byte of frame; qualified by rx_vld.
- rx_eof  in  1  last byte of frame (last FCS byte); qualified by rx_vld.
- out_vld  out  1  output byte valid.
- out_dat  out  8  output payload byte.
- out_sof  out  1  first payload byte.
- out_eof  out  1  last payload byte.
- out_err  out  1  frame bad; meaningful only when out_vld && out_eof.
- stat_good  out  1  one-cycle pulse per good frame.
- stat_bad  out  1  one-cycle pulse per bad or aborted frame.
- good_cnt  out  CNT_W  count of good frames; wraps.
- bad_cnt  out  CNT_W  count of bad frames; wraps.

Behaviour:
- Reset: every output is 0. Internal state is cleared: shift register, byte count, CRC reg = 0xFFFFFFFF, state IDLE.
- An asynchronous rst mid-frame discards the frame silently. No eof and no stat pulse are produced for it.
- States:
  - IDLE: rx_vld without rx_sof is ignored. rx_vld && rx_sof goes to FRAME with count=1, crc=next(0xFFFFFFFF, byte), sr[0]=byte.
  - FRAME: each rx_vld shifts the byte in at sr[0] (sr[3] is oldest), updates crc, and does count+1 saturating at 2^16-1.
- Emission: on an accepted byte with count (pre-increment) >= 4, sr[3] is registered to out_dat.
  - out_vld is high the next cycle, 1 cycle latency.
  - out_sof=1 when pre-increment count == 4.
  - Outputs are single-cycle strobes; out_vld is 0 in all other cycles.
- CRC: reflected CRC-32, poly 0xEDB88320, init 0xFFFFFFFF, no final XOR. The frame is good iff the CRC including the eof byte equals residue 0xDEBB20E3.
- End of frame (rx_vld && rx_eof in FRAME), final length L = count+1:
  - out_err = (crc != residue) || L < MIN_LEN || L > MAX_LEN.
  - If L >= 5: the emitted byte carries out_eof=1 and out_err.
  - If L <= 4: nothing is emitted; the frame is bad.
  - stat_good or stat_bad pulses in the same cycle as out_eof (or the equivalent cycle if nothing is emitted).
  - The matching counter increments on that pulse. Return to IDLE.
  - rx_eof with rx_sof on the same byte counts as a 1-byte frame: bad, nothing emitted.
- rx_sof arriving in FRAME is an abort of the old frame plus the start of a new one:
  - If the old frame already emitted output (count >= 5), emit sr[3] with out_eof=1, out_err=1.
  - Otherwise emit nothing.
  - stat_bad pulses and bad_cnt increments.
  - The new frame starts in the same cycle with count=1.
- Counters wrap at 2^CNT_W.

Decomposition:
- Package eth_pkg holds:
  - CRC32_POLY (0xEDB88320), CRC32_INIT (0xFFFFFFFF), CRC32_RESIDUE (0xDEBB20E3).
  - ETH_MIN_LEN (64) and ETH_MAX_LEN (1522).
- Sub-module crc32_d8: purely combinational, (crc_in[31:0], dat[7:0]) -> crc_out. It is shared with eth_tx FCS generation.
- Top level holds the FSM, delay line, counters and output registers.

Test Plan:
- 64-byte frame (60 payload: dst ff×6, src 00×6, de ad be ef, zeros, last payload byte ff) with correct FCS, driven through eth_tx -> eth_rx loopback:
  - 60 out_vld bytes; out_sof on 0xff at byte 0; out_eof on byte 59 = 0xff with out_err=0.
  - stat_good pulse; good_cnt=1.
- Same frame with bit 0 of byte 20 flipped: 60 bytes out, out_eof with out_err=1, bad_cnt=1, good_cnt unchanged.
- 24-byte frame (20 payload + valid FCS): 20 bytes out, out_err=1 (L<64), stat_bad.
- 3-byte frame: no out_vld at all, stat_bad pulse, bad_cnt+1. Then rx_vld bytes without sof produce no output.
- 30 bytes of a frame, then a new rx_sof:
  - Old frame: out_eof=1, out_err=1 on the emitted byte (old byte 26).
  - The following valid 64-byte frame passes with out_err=0.
- rst asserted after byte 40 of a frame: all outputs 0 immediately, counters 0, no eof. The next valid frame passes cleanly.
